pipe_stage_buf: RTL and testbench

- Generic, parametrised inter-stage pipeline register replacing the hand-written per-stage latches (e.g. the M->W stage).
- Carries an opaque payload bus of DATA_W bits under a valid/allowin handshake, with a synchronous flush for exception redirect.
- Optional second (skid) entry, selected by SKID, registers the upstream allowin. This breaks the combinational allowin chain without losing throughput.
- Instantiated between every pair of pipeline stages. Stage-specific fields are packed into and unpacked from the payload bus by the surrounding stage logic.

---
 rtl/pipe_pkg.sv | 37 +++
 rtl/pipe_slot.sv | 63 ++++++
 rtl/pipe_stage_buf.sv | 118 +++++++++++
 tb/tb_pipe_stage_buf.sv | 206 ++++++++++++++++++++
 4 files changed

// File: rtl/pipe_pkg.sv
// Shared pipeline-stage definitions: occupancy width, the M->W payload layout
// and small helpers used by the stage buffers.
package pipe_pkg;

   localparam int OCC_W      = 2;
   localparam int REGWRITE_W = 1;
   localparam int A3_W       = 5;
   localparam int WORD_W     = 32;

   // Fields are listed MSB first; regwrite sits at bit 0 of the bus.
   typedef struct packed {
      logic [WORD_W-1:0] cp0;
      logic [WORD_W-1:0] hi;
      logic [WORD_W-1:0] lo;
      logic [WORD_W-1:0] pc;
      logic [WORD_W-1:0] memout;
      logic [WORD_W-1:0] aluout;
      logic [A3_W-1:0]   a3;
      logic              regwrite;
   } mw_payload_t;

   localparam int MW_PAYLOAD_W    = $bits(mw_payload_t);
   localparam int MW_REGWRITE_OFF = 0;
   localparam int MW_A3_OFF       = MW_REGWRITE_OFF + REGWRITE_W;
   localparam int MW_ALUOUT_OFF   = MW_A3_OFF + A3_W;
   localparam int MW_MEMOUT_OFF   = MW_ALUOUT_OFF + WORD_W;
   localparam int MW_PC_OFF       = MW_MEMOUT_OFF + WORD_W;
   localparam int MW_LO_OFF       = MW_PC_OFF + WORD_W;
   localparam int MW_HI_OFF       = MW_LO_OFF + WORD_W;
   localparam int MW_CP0_OFF      = MW_HI_OFF + WORD_W;

   function automatic logic [OCC_W-1:0] occ_count(input logic main_valid,
                                                  input logic skid_valid);
      occ_count = {1'b0, main_valid} + {1'b0, skid_valid};
   endfunction

endpackage

// File: rtl/pipe_slot.sv
// One pipeline entry: a valid bit plus a DATA_W payload register with
// independent valid/data load enables and a synchronous clear.
module pipe_slot
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int RESET_DATA = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              clear,
   input  logic              valid_en,
   input  logic              valid_d,
   input  logic              data_en,
   input  logic [DATA_W-1:0] data_d,
   output logic              valid,
   output logic [DATA_W-1:0] data
);

   logic              valid_r;
   logic [DATA_W-1:0] data_r;

   // Valid bit: reset and clear both empty the entry.
   always_ff @(posedge clk) begin
      if (!reset) begin
         valid_r <= 1'b0;
      end else if (clear) begin
         valid_r <= 1'b0;
      end else if (valid_en) begin
         valid_r <= valid_d;
      end else begin
         valid_r <= valid_r;
      end
   end

   generate
      if (RESET_DATA != 0) begin : g_rst_data
         // Payload with reset: zeroed on reset and on clear.
         always_ff @(posedge clk) begin
            if (!reset || clear) begin
               data_r <= {DATA_W{1'b0}};
            end else if (data_en) begin
               data_r <= data_d;
            end else begin
               data_r <= data_r;
            end
         end
      end else begin : g_keep_data
         // Payload without reset: only written by a real load.
         always_ff @(posedge clk) begin
            if (data_en && reset && !clear) begin
               data_r <= data_d;
            end else begin
               data_r <= data_r;
            end
         end
      end
   endgenerate

   assign valid = valid_r;
   assign data  = data_r;

endmodule

// File: rtl/pipe_stage_buf.sv
// Inter-stage pipeline register with valid/allowin handshake and flush;
// SKID=1 adds a second entry so in_allowin comes straight from a register.
module pipe_stage_buf
   import pipe_pkg::*;
#(
   parameter int DATA_W     = 32,
   parameter int SKID       = 0,
   parameter int RESET_DATA = 0
) (
   input  logic              clk,
   input  logic              reset,
   input  logic              flush,
   input  logic              in_valid,
   input  logic [DATA_W-1:0] in_data,
   output logic              in_allowin,
   output logic              out_valid,
   output logic [DATA_W-1:0] out_data,
   input  logic              out_allowin,
   output logic [OCC_W-1:0]  occupancy
);

   logic              main_valid_s;
   logic [DATA_W-1:0] main_data_s;
   logic              main_valid_en_s;
   logic              main_valid_d_s;
   logic              main_data_en_s;
   logic [DATA_W-1:0] main_data_d_s;
   logic              skid_valid_s;
   logic              acc_s;
   logic              pop_s;

   assign acc_s = in_valid && in_allowin;
   assign pop_s = main_valid_s && out_allowin;

   pipe_slot #(
      .DATA_W     (DATA_W),
      .RESET_DATA (RESET_DATA)
   ) u_main (
      .clk      (clk),
      .reset    (reset),
      .clear    (flush),
      .valid_en (main_valid_en_s),
      .valid_d  (main_valid_d_s),
      .data_en  (main_data_en_s),
      .data_d   (main_data_d_s),
      .valid    (main_valid_s),
      .data     (main_data_s)
   );

   generate
      if (SKID == 0) begin : g_single
         assign skid_valid_s    = 1'b0;
         assign in_allowin      = !main_valid_s || out_allowin;
         assign main_valid_en_s = in_allowin;
         assign main_valid_d_s  = in_valid;
         assign main_data_en_s  = acc_s;
         assign main_data_d_s   = in_data;
      end else begin : g_skid
         logic              skid_valid_en_s;
         logic              skid_valid_d_s;
         logic              skid_data_en_s;
         logic [DATA_W-1:0] skid_data_s;

         pipe_slot #(
            .DATA_W     (DATA_W),
            .RESET_DATA (RESET_DATA)
         ) u_skid (
            .clk      (clk),
            .reset    (reset),
            .clear    (flush),
            .valid_en (skid_valid_en_s),
            .valid_d  (skid_valid_d_s),
            .data_en  (skid_data_en_s),
            .data_d   (in_data),
            .valid    (skid_valid_s),
            .data     (skid_data_s)
         );

         // Upstream only sees the skid register, never out_allowin.
         assign in_allowin = !skid_valid_s;

         // Entry steering: refill main from skid first, else from input.
         always_comb begin
            main_valid_en_s = 1'b0;
            main_valid_d_s  = 1'b0;
            main_data_en_s  = 1'b0;
            main_data_d_s   = in_data;
            skid_valid_en_s = 1'b0;
            skid_valid_d_s  = 1'b0;
            skid_data_en_s  = 1'b0;
            if (!main_valid_s || pop_s) begin
               main_valid_en_s = 1'b1;
               if (skid_valid_s) begin
                  main_valid_d_s  = 1'b1;
                  main_data_en_s  = 1'b1;
                  main_data_d_s   = skid_data_s;
                  skid_valid_en_s = 1'b1;
                  skid_valid_d_s  = 1'b0;
               end else begin
                  main_valid_d_s = acc_s;
                  main_data_en_s = acc_s;
               end
            end else if (acc_s) begin
               skid_valid_en_s = 1'b1;
               skid_valid_d_s  = 1'b1;
               skid_data_en_s  = 1'b1;
            end else begin
               skid_valid_en_s = 1'b0;
            end
         end
      end
   endgenerate

   assign out_valid = main_valid_s;
   assign out_data  = main_data_s;
   assign occupancy = occ_count(main_valid_s, skid_valid_s);

endmodule

// File: tb/tb_pipe_stage_buf.sv
// Bench for pipe_stage_buf: three instances (SKID=0, SKID=1, SKID=1 without
// payload reset) against capacity-limited queue models plus directed literals.
module tb_pipe_stage_buf;

   localparam int DW = 97;

   logic          clk = 1'b0;
   logic          reset;
   logic          flush;
   logic          in_valid;
   logic [DW-1:0] in_data;
   logic          out_allowin;

   logic          d0_ia, d0_ov, d1_ia, d1_ov, d2_ia, d2_ov;
   logic [DW-1:0] d0_od, d1_od, d2_od;
   logic [1:0]    d0_occ, d1_occ, d2_occ;

   int n_checks = 0;
   int n_fail   = 0;
   bit chk_en   = 1'b0;
   bit dead_seen = 1'b0;

   logic [DW-1:0] q0[$];   // expected contents, capacity 1
   logic [DW-1:0] q1[$];   // expected contents, capacity 2

   always #5 clk = ~clk;

   pipe_stage_buf #(.DATA_W(DW), .SKID(0), .RESET_DATA(1)) u_s0 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_allowin(d0_ia), .out_valid(d0_ov), .out_data(d0_od), .out_allowin(out_allowin),
      .occupancy(d0_occ));

   pipe_stage_buf #(.DATA_W(DW), .SKID(1), .RESET_DATA(1)) u_s1 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_allowin(d1_ia), .out_valid(d1_ov), .out_data(d1_od), .out_allowin(out_allowin),
      .occupancy(d1_occ));

   pipe_stage_buf #(.DATA_W(DW), .SKID(1), .RESET_DATA(0)) u_s2 (
      .clk(clk), .reset(reset), .flush(flush), .in_valid(in_valid), .in_data(in_data),
      .in_allowin(d2_ia), .out_valid(d2_ov), .out_data(d2_od), .out_allowin(out_allowin),
      .occupancy(d2_occ));

   task automatic check(input string name, input logic [127:0] act, input logic [127:0] exp);
      n_checks++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", name, act, exp);
      end
   endtask

   task automatic step();
      @(posedge clk);
      #1;
   endtask

   function automatic logic [DW-1:0] rnd_data();
      logic [127:0] t;
      t = {$urandom(), $urandom(), $urandom(), $urandom()};
      return t[DW-1:0];
   endfunction

   // Reference model: a stage is a FIFO of bounded capacity; SKID=0 accepts
   // when empty or draining, SKID=1 accepts whenever fewer than two are held.
   always @(posedge clk) begin
      if (!reset || flush) begin
         q0.delete();
         q1.delete();
      end else begin
         if (q0.size() != 0 && out_allowin) begin
            void'(q0.pop_front());
            if (in_valid) q0.push_back(in_data);
         end else if (q0.size() == 0 && in_valid) begin
            q0.push_back(in_data);
         end
         if (q1.size() != 0 && out_allowin) begin
            void'(q1.pop_front());
            if (in_valid && q1.size() == 0) q1.push_back(in_data);
         end else if (in_valid && q1.size() < 2) begin
            q1.push_back(in_data);
         end
      end
   end

   // Per-cycle comparison against the model, plus the handshake invariants.
   always @(negedge clk) begin
      if (chk_en) begin
         check("s0_valid", d0_ov, q0.size() != 0);
         check("s0_occ", d0_occ, q0.size());
         check("s0_allowin", d0_ia, (q0.size() == 0) || out_allowin);
         if (q0.size() != 0) check("s0_data", d0_od, q0[0]);
         check("s1_valid", d1_ov, q1.size() != 0);
         check("s1_occ", d1_occ, q1.size());
         check("s1_allowin", d1_ia, q1.size() < 2);
         if (q1.size() != 0) check("s1_data", d1_od, q1[0]);
         check("s2_valid", d2_ov, q1.size() != 0);
         check("s2_occ", d2_occ, q1.size());
         check("s2_allowin", d2_ia, q1.size() < 2);
         if (q1.size() != 0) check("s2_data", d2_od, q1[0]);
         check("s0_valid_vs_occ", d0_ov, d0_occ != 2'd0);
         check("s1_valid_vs_occ", d1_ov, d1_occ != 2'd0);
         check("s2_valid_vs_occ", d2_ov, d2_occ != 2'd0);
         check("s1_acc_when_full", (d1_occ == 2'd2) && in_valid && d1_ia, 1'b0);
         check("s2_acc_when_full", (d2_occ == 2'd2) && in_valid && d2_ia, 1'b0);
         if ((d0_ov && d0_od == 97'hDEADBEEF) || (d1_ov && d1_od == 97'hDEADBEEF) ||
             (d2_ov && d2_od == 97'hDEADBEEF))
            dead_seen <= 1'b1;
      end
   end

   initial begin
      // Reset held two cycles with a valid input presented
      reset = 1'b0; flush = 1'b0; in_valid = 1'b1; in_data = rnd_data(); out_allowin = 1'b0;
      step();
      chk_en = 1'b1;
      step();
      check("rst_s0_valid", d0_ov, 1'b0);
      check("rst_s1_valid", d1_ov, 1'b0);
      check("rst_s0_occ", d0_occ, 2'd0);
      check("rst_s1_occ", d1_occ, 2'd0);
      check("rst_s0_allowin", d0_ia, 1'b1);
      check("rst_s1_allowin", d1_ia, 1'b1);
      check("rst_s0_data", d0_od, 97'd0);
      check("rst_s1_data", d1_od, 97'd0);

      // Back-to-back streaming 1..16
      reset = 1'b1; out_allowin = 1'b1;
      for (int i = 1; i <= 16; i++) begin
         in_valid = 1'b1;
         in_data  = DW'(i);
         step();
         check("stream_s0_data", d0_od, 128'(i));
         check("stream_s1_data", d1_od, 128'(i));
         check("stream_s1_occ", d1_occ, 2'd1);
      end
      in_valid = 1'b0;
      step();
      check("stream_drain_s0", d0_occ, 2'd0);
      check("stream_drain_s1", d1_occ, 2'd0);

      // Backpressure: A into main, then B lands in skid while stalled
      in_valid = 1'b1; in_data = 97'hAAAA0001; out_allowin = 1'b1;
      step();
      out_allowin = 1'b0; in_data = 97'hBBBB0002;
      step();
      check("bp_occ2", d1_occ, 2'd2);
      check("bp_allowin_low", d1_ia, 1'b0);
      check("bp_hold_a", d1_od, 97'hAAAA0001);
      in_valid = 1'b0;
      step();
      check("bp_still_a", d1_od, 97'hAAAA0001);
      out_allowin = 1'b1;
      step();
      check("bp_b_in_main", d1_od, 97'hBBBB0002);
      check("bp_occ1", d1_occ, 2'd1);
      check("bp_allowin_back", d1_ia, 1'b1);
      step();
      check("bp_empty", d1_ov, 1'b0);

      // Flush while full, with an input transfer in the same cycle
      out_allowin = 1'b0; in_valid = 1'b1; in_data = 97'h0C0C0001;
      step();
      in_data = 97'h0C0C0002;
      step();
      check("fl_pre_occ2", d1_occ, 2'd2);
      flush = 1'b1; out_allowin = 1'b1; in_data = 97'hDEADBEEF;
      step();
      flush = 1'b0; in_valid = 1'b0;
      check("fl_s1_occ", d1_occ, 2'd0);
      check("fl_s1_valid", d1_ov, 1'b0);
      check("fl_s0_valid", d0_ov, 1'b0);
      check("fl_s1_data_clr", d1_od, 97'd0);
      check("fl_s0_data_clr", d0_od, 97'd0);
      repeat (3) step();
      check("fl_no_deadbeef", dead_seen, 1'b0);

      // Reset and flush together
      reset = 1'b0; flush = 1'b1; in_valid = 1'b1; in_data = 97'h5A5A5A5A;
      step();
      check("rf_s0_valid", d0_ov, 1'b0);
      check("rf_s1_occ", d1_occ, 2'd0);
      check("rf_s1_allowin", d1_ia, 1'b1);
      reset = 1'b1; flush = 1'b0; in_data = 97'h12345678; out_allowin = 1'b0;
      step();
      in_valid = 1'b0;
      check("rf_s0_push", d0_od, 97'h12345678);
      check("rf_s1_push", d1_od, 97'h12345678);
      check("rf_s2_push", d2_od, 97'h12345678);
      check("rf_s1_valid", d1_ov, 1'b1);

      // Random stress with ~10% flush rate
      for (int c = 0; c < 3000; c++) begin
         flush       = ($urandom_range(0, 9) == 0);
         in_valid    = $urandom_range(0, 1) != 0;
         out_allowin = $urandom_range(0, 1) != 0;
         in_data     = rnd_data();
         step();
      end
      flush = 1'b0; in_valid = 1'b0; out_allowin = 1'b1;
      repeat (3) step();
      check("final_s1_empty", d1_occ, 2'd0);

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
